// File: rtl/mode_select_pkg.sv
// Shared types for the push-button mode sequencer: mode codes used by the
// display multiplexer and the per-key debounce state encoding.
package mode_select_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam mode_t MODE_0 = 2'd0;
  localparam mode_t MODE_1 = 2'd1;
  localparam mode_t MODE_2 = 2'd2;
  localparam mode_t MODE_3 = 2'd3;

  // Modulo-num_modes increment; num_modes is expected in 2..4.
  function automatic mode_t next_mode(input mode_t m, input int unsigned num_modes);
    if (m == mode_t'(num_modes - 1)) begin
      return MODE_0;
    end
    return m + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low push button: 2-flop synchroniser, stability counter and
// press/release FSM. o_pressed is active-high and registered off the FSM state.
module key_debounce
  import mode_select_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic [1:0]       r_sync;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  db_state_t        r_state;
  logic             r_pressed;

  logic w_s;
  logic w_differ;
  logic w_expire;

  assign w_s      = r_sync[1];
  assign w_differ = (w_s != r_db);
  assign w_expire = w_differ && (r_cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= 2'b11;
      r_db      <= 1'b1;
      r_cnt     <= '0;
      r_state   <= RELEASED;
      r_pressed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};

      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_cnt <= '0;
        r_db  <= w_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A revert before expiry returns to the settled state; the counter has
      // already been cleared by the equality path above.
      case (r_state)
        RELEASED:     if (!w_s) r_state <= PRESS_WAIT;
        PRESS_WAIT: begin
          if (w_s)           r_state <= RELEASED;
          else if (w_expire) r_state <= PRESSED;
        end
        PRESSED:      if (w_s) r_state <= RELEASE_WAIT;
        RELEASE_WAIT: begin
          if (!w_s)          r_state <= PRESSED;
          else if (w_expire) r_state <= RELEASED;
        end
        default:      r_state <= RELEASED;
      endcase

      r_pressed <= (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    end
  end

  assign o_pressed = r_pressed;

endmodule

// File: rtl/mode_select.sv
// Debounced KEY front end and display-mode sequencer. KEY0 press advances the
// mode, KEY0 with KEY1 held clears it. Optional auto-repeat: MODE_SELECT_AUTOREPEAT_EN.
module mode_select
  import mode_select_pkg::*;
#(
  parameter int DB_CYCLES     = 500000,
  parameter int NUM_MODES     = 4,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst_n,
  input  logic [1:0] KEY,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic [1:0] key_pressed
);

  logic [1:0] w_key_pressed;
  logic       r_kp0_d;
  mode_t      r_mode;
  logic       r_mode_change;
  logic       w_press_evt;
  logic       w_repeat;
  logic       w_event;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_key_debounce (
        .i_clk     (MAX10_CLK1_50),
        .i_rst_n   (rst_n),
        .i_key_n   (KEY[gi]),
        .o_pressed (w_key_pressed[gi])
      );
    end
  endgenerate

  assign w_press_evt = w_key_pressed[0] && !r_kp0_d;

`ifdef MODE_SELECT_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;

  logic [RPT_W-1:0] r_rpt_cnt;

  // Timer restarts at acceptance so repeats land REPEAT_CYCLES apart from it.
  assign w_repeat = w_key_pressed[0] && r_kp0_d &&
                    (r_rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_cnt <= '0;
    end else if (!w_key_pressed[0] || w_press_evt || w_repeat) begin
      r_rpt_cnt <= '0;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
    end
  end
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYCLES > 0);
  assign w_repeat        = 1'b0;
`endif

  assign w_event = w_press_evt || w_repeat;

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_kp0_d       <= 1'b0;
      r_mode        <= MODE_0;
      r_mode_change <= 1'b0;
    end else begin
      r_kp0_d       <= w_key_pressed[0];
      r_mode_change <= w_event;
      if (w_event) begin
        r_mode <= w_key_pressed[1] ? MODE_0 : next_mode(r_mode, NUM_MODES);
      end
    end
  end

  assign mode        = r_mode;
  assign mode_change = r_mode_change;
  assign key_pressed = w_key_pressed;

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select with DB_CYCLES=4, NUM_MODES=4, REPEAT_CYCLES=20.
// Cycle k below means the negedge following the k-th rising edge (0-based) after a KEY change.
module tb_mode_select;

  logic       clk;
  logic       rst_n;
  logic [1:0] KEY;
  logic [1:0] mode;
  logic       mode_change;
  logic [1:0] key_pressed;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  bit kp0_seen  = 0;

  mode_select #(
    .DB_CYCLES     (4),
    .NUM_MODES     (4),
    .REPEAT_CYCLES (20)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .KEY           (KEY),
    .mode          (mode),
    .mode_change   (mode_change),
    .key_pressed   (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (mode_change === 1'b1) pulse_cnt++;
    if (key_pressed[0] === 1'b1) kp0_seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    KEY   = 2'b11;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  // KEY0 press of 10 cycles followed by 10 released cycles.
  task automatic press_key0();
    KEY = 2'b10;
    step(10);
    KEY = 2'b11;
    step(10);
  endtask

  task automatic test_reset();
    @(negedge clk);
    KEY   = 2'b00;
    rst_n = 1'b0;
    step(3);
    checks++;
    if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++;
    if (mode_change !== 1'b0) begin failures++; $display("FAIL reset_mode_change got=%b exp=0", mode_change); end
    checks++;
    if (key_pressed !== 2'b00) begin failures++; $display("FAIL reset_key_pressed got=%b exp=00", key_pressed); end
    KEY   = 2'b10;
    rst_n = 1'b1;
    pulse_cnt = 0;
    step(6);
    checks++;
    if (key_pressed !== 2'b00) begin failures++; $display("FAIL reset_kp_cycle5 got=%b exp=00", key_pressed); end
    step(1);
    checks++;
    if (key_pressed !== 2'b01 || mode !== 2'd0) begin
      failures++; $display("FAIL reset_kp_cycle6 got kp=%b mode=%0d exp kp=01 mode=0", key_pressed, mode);
    end
    step(1);
    checks++;
    if (mode !== 2'd1 || mode_change !== 1'b1) begin
      failures++; $display("FAIL reset_mode_cycle7 got mode=%0d mc=%b exp mode=1 mc=1", mode, mode_change);
    end
    step(1);
    checks++;
    if (mode_change !== 1'b0 || pulse_cnt != 1) begin
      failures++; $display("FAIL reset_single_pulse got mc=%b pulses=%0d exp mc=0 pulses=1", mode_change, pulse_cnt);
    end
    KEY = 2'b11;
    step(12);
    $display("test_reset done mode=%0d", mode);
  endtask

  task automatic test_four_presses();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
    do_reset();
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      press_key0();
      checks++;
      if (mode !== exp_seq[i] || pulse_cnt != i + 1) begin
        failures++;
        $display("FAIL press%0d got mode=%0d pulses=%0d exp mode=%0d pulses=%0d", i, mode, pulse_cnt, exp_seq[i], i + 1);
      end
      $display("press %0d mode=%0d pulses=%0d", i, mode, pulse_cnt);
    end
  endtask

  task automatic test_glitch();
    logic [1:0] m0;
    int p0;
    do_reset();
    m0 = mode;
    p0 = pulse_cnt;
    kp0_seen = 1'b0;
    KEY = 2'b10;
    step(3);
    KEY = 2'b11;
    step(12);
    checks++;
    if (kp0_seen !== 1'b0 || mode !== m0 || pulse_cnt != p0) begin
      failures++; $display("FAIL glitch3 got kp_seen=%b mode=%0d exp kp_seen=0 mode=%0d", kp0_seen, mode, m0);
    end
    KEY = 2'b10;
    step(6);
    KEY = 2'b11;
    step(12);
    checks++;
    if (mode !== 2'd1 || pulse_cnt != p0 + 1) begin
      failures++; $display("FAIL press6 got mode=%0d pulses=%0d exp mode=1 pulses=%0d", mode, pulse_cnt, p0 + 1);
    end
    $display("test_glitch done mode=%0d", mode);
  endtask

  task automatic test_clear();
    int p0;
    do_reset();
    press_key0();
    press_key0();
    checks++;
    if (mode !== 2'd2) begin failures++; $display("FAIL clear_setup got=%0d exp=2", mode); end
    p0 = pulse_cnt;
    KEY = 2'b01;
    step(10);
    checks++;
    if (mode !== 2'd2 || pulse_cnt != p0 || key_pressed !== 2'b10) begin
      failures++; $display("FAIL key1_alone got mode=%0d kp=%b pulses=%0d exp mode=2 kp=10 pulses=%0d", mode, key_pressed, pulse_cnt, p0);
    end
    KEY = 2'b00;
    step(10);
    checks++;
    if (mode !== 2'd0 || pulse_cnt != p0 + 1) begin
      failures++; $display("FAIL clear_from2 got mode=%0d pulses=%0d exp mode=0 pulses=%0d", mode, pulse_cnt, p0 + 1);
    end
    KEY = 2'b01;
    step(10);
    KEY = 2'b00;
    step(10);
    checks++;
    if (mode !== 2'd0 || pulse_cnt != p0 + 2) begin
      failures++; $display("FAIL clear_at0 got mode=%0d pulses=%0d exp mode=0 pulses=%0d", mode, pulse_cnt, p0 + 2);
    end
    KEY = 2'b11;
    step(12);
    checks++;
    if (mode !== 2'd0 || key_pressed !== 2'b00 || pulse_cnt != p0 + 2) begin
      failures++; $display("FAIL clear_release got mode=%0d kp=%b exp mode=0 kp=00", mode, key_pressed);
    end
    $display("test_clear done mode=%0d", mode);
  endtask

  task automatic test_both_same_edge();
    do_reset();
    press_key0();
    press_key0();
    press_key0();
    checks++;
    if (mode !== 2'd3) begin failures++; $display("FAIL both_setup got=%0d exp=3", mode); end
    KEY = 2'b00;
    step(7);
    checks++;
    if (mode !== 2'd3 || key_pressed !== 2'b11) begin
      failures++; $display("FAIL both_cycle6 got mode=%0d kp=%b exp mode=3 kp=11", mode, key_pressed);
    end
    step(1);
    checks++;
    if (mode !== 2'd0 || mode_change !== 1'b1) begin
      failures++; $display("FAIL both_cycle7 got mode=%0d mc=%b exp mode=0 mc=1", mode, mode_change);
    end
    KEY = 2'b11;
    step(12);
    $display("test_both_same_edge done mode=%0d", mode);
  endtask

  task automatic test_autorepeat();
    int p0;
    do_reset();
    p0 = pulse_cnt;
    KEY = 2'b10;
    step(8);
    checks++;
    if (mode !== 2'd1) begin failures++; $display("FAIL rpt_cycle7 got=%0d exp=1", mode); end
    step(19);
    checks++;
    if (mode !== 2'd1) begin failures++; $display("FAIL rpt_cycle26 got=%0d exp=1", mode); end
    step(1);
`ifdef MODE_SELECT_AUTOREPEAT_EN
    checks++;
    if (mode !== 2'd2 || mode_change !== 1'b1) begin
      failures++; $display("FAIL rpt_cycle27 got mode=%0d mc=%b exp mode=2 mc=1", mode, mode_change);
    end
    step(20);
    checks++;
    if (mode !== 2'd3) begin failures++; $display("FAIL rpt_cycle47 got=%0d exp=3", mode); end
    step(20);
    checks++;
    if (mode !== 2'd0) begin failures++; $display("FAIL rpt_cycle67 got=%0d exp=0", mode); end
    step(3);
    KEY = 2'b11;
    step(12);
    checks++;
    if (mode !== 2'd0 || pulse_cnt != p0 + 4) begin
      failures++; $display("FAIL rpt_total got mode=%0d pulses=%0d exp mode=0 pulses=%0d", mode, pulse_cnt, p0 + 4);
    end
`else
    checks++;
    if (mode !== 2'd1 || mode_change !== 1'b0) begin
      failures++; $display("FAIL norpt_cycle27 got mode=%0d mc=%b exp mode=1 mc=0", mode, mode_change);
    end
    step(43);
    KEY = 2'b11;
    step(12);
    checks++;
    if (mode !== 2'd1 || pulse_cnt != p0 + 1) begin
      failures++; $display("FAIL norpt_total got mode=%0d pulses=%0d exp mode=1 pulses=%0d", mode, pulse_cnt, p0 + 1);
    end
`endif
    $display("test_autorepeat done mode=%0d", mode);
  endtask

  initial begin
    rst_n = 1'b0;
    KEY   = 2'b11;
    test_reset();
    test_four_presses();
    test_glitch();
    test_clear();
    test_both_same_edge();
    test_autorepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
